// File: rtl/arb_l1_pkg.sv
// Shared types and limits for the L1 round-robin arbiter.
// Imported by the arbiter top and its read-ID FIFO.
package arb_l1_pkg;

    localparam int MAX_N_MASTERS = 8;
    localparam int MAX_OUTST_LIM = 16;

    typedef logic [2:0] master_id_t;

    typedef struct packed {
        logic       vld;
        master_id_t id;
    } grant_t;

endpackage

// File: rtl/arb_l1_if.sv
// MemSplit32: split-transaction 32-bit memory bus.
// Requests complete on req&&ack; read data returns later on resp.
interface MemSplit32;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport Slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );

endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of master IDs for reads awaiting a response.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of 2.
module arb_id_fifo #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_cnt == CW'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd];
    assign count  = r_cnt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/arb_l1_rr.sv
// Round-robin arbiter of N MemSplit32 masters onto one slave,
// routing in-order read responses back via an ID FIFO.
module arb_l1_rr
    import arb_l1_pkg::*;
#(
    parameter  int N_MASTERS = 4,
    parameter  int MAX_OUTST = 4,
    localparam int OW        = $clog2(MAX_OUTST + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    MemSplit32.Slave        m [N_MASTERS],
    MemSplit32.Master       s,
    output logic [OW-1:0]   outst_o,
    output logic            err_o
);

    logic [N_MASTERS-1:0] w_req;
    logic [N_MASTERS-1:0] w_we;
    logic [N_MASTERS-1:0] w_elig;
    logic [31:0]          w_addr  [N_MASTERS];
    logic [31:0]          w_wdata [N_MASTERS];
    logic [3:0]           w_be    [N_MASTERS];
    grant_t               w_gnt;
    logic                 w_s_we;
    logic [31:0]          w_s_addr;
    logic [31:0]          w_s_wdata;
    logic [3:0]           w_s_be;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_route;
    logic                 w_full;
    logic                 w_empty;
    master_id_t           w_head;
    master_id_t           r_rr_ptr;
    logic                 r_err;

    // Lowest rotated offset wins; scanning downward avoids a break.
    function automatic grant_t rr_pick(
        input logic [N_MASTERS-1:0] cand,
        input master_id_t           ptr
    );
        grant_t g;
        int     idx;
        g = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (cand[idx]) begin
                g.vld = 1'b1;
                g.id  = master_id_t'(idx);
            end
        end
        return g;
    endfunction

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
        logic w_sel;
        logic w_own;
        assign w_req[i]   = m[i].req;
        assign w_we[i]    = m[i].we;
        assign w_addr[i]  = m[i].addr;
        assign w_wdata[i] = m[i].wdata;
        assign w_be[i]    = m[i].be;
        assign w_sel      = w_gnt.vld && (w_gnt.id == master_id_t'(i));
        assign w_own      = w_route && (w_head == master_id_t'(i));
        assign m[i].ack   = w_sel && s.ack;
        assign m[i].resp  = w_own;
        assign m[i].rdata = w_own ? s.rdata : '0;
    end

    assign w_elig = w_req & (w_we | {N_MASTERS{!w_full}});
    assign w_gnt  = rr_pick(w_elig, r_rr_ptr);

    always_comb begin
        w_s_we    = 1'b0;
        w_s_addr  = '0;
        w_s_wdata = '0;
        w_s_be    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_gnt.vld && w_gnt.id == master_id_t'(i)) begin
                w_s_we    = w_we[i];
                w_s_addr  = w_addr[i];
                w_s_wdata = w_wdata[i];
                w_s_be    = w_be[i];
            end
        end
    end

    assign s.req   = w_gnt.vld;
    assign s.we    = w_s_we;
    assign s.addr  = w_s_addr;
    assign s.wdata = w_s_wdata;
    assign s.be    = w_s_be;

    assign w_accept = w_gnt.vld && s.ack;
    assign w_push   = w_accept && !w_s_we;
    assign w_route  = s.resp && !w_empty;

    arb_id_fifo #(
        .WIDTH ($bits(master_id_t)),
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_push),
        .pop   (w_route),
        .din   (w_gnt.id),
        .dout  (w_head),
        .count (outst_o),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept)
                r_rr_ptr <= (w_gnt.id == master_id_t'(N_MASTERS - 1))
                          ? '0 : w_gnt.id + 1'b1;
            if (s.resp && w_empty)
                r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_arb_l1_rr.sv
// Directed bench for arb_l1_rr with N_MASTERS=4, MAX_OUTST=4.
// Each step drives inputs, then checks against hand-computed values.
module tb_arb_l1_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  tb_req = '0;
    logic [3:0]  tb_we  = '0;
    logic [31:0] tb_addr  [4];
    logic [31:0] tb_wdata [4];
    logic [3:0]  tb_be    [4];
    logic        s_ack   = 1'b0;
    logic        s_resp  = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [3:0]  ack_v;
    logic [3:0]  resp_v;
    logic [31:0] rd_a [4];
    logic [2:0]  outst;
    logic        err;
    int          n_cmp = 0;
    int          n_bad = 0;

    MemSplit32 m_if [4] ();
    MemSplit32 s_if ();

    for (genvar g = 0; g < 4; g++) begin : g_if
        assign m_if[g].req   = tb_req[g];
        assign m_if[g].we    = tb_we[g];
        assign m_if[g].addr  = tb_addr[g];
        assign m_if[g].wdata = tb_wdata[g];
        assign m_if[g].be    = tb_be[g];
        assign ack_v[g]      = m_if[g].ack;
        assign resp_v[g]     = m_if[g].resp;
        assign rd_a[g]       = m_if[g].rdata;
    end

    assign s_if.ack   = s_ack;
    assign s_if.resp  = s_resp;
    assign s_if.rdata = s_rdata;

    arb_l1_rr #(
        .N_MASTERS (4),
        .MAX_OUTST (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m       (m_if),
        .s       (s_if),
        .outst_o (outst),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] we);
        tb_req = req;
        tb_we  = we;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tb_addr[i]  = 32'h100 * (i + 1);
            tb_wdata[i] = 32'hD000 + i;
            tb_be[i]    = 4'(i + 1);
        end

        // Reset state
        #12;
        chk("rst_outst", 32'(outst), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sreq", 32'(s_if.req), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // m1/m3 writes alternate
        s_ack = 1'b1;
        drive(4'b1010, 4'b1010);
        chk("wr_g1_ack", 32'(ack_v), 32'b0010);
        chk("wr_g1_addr", s_if.addr, 32'h200);
        chk("wr_g1_wdata", s_if.wdata, 32'hD001);
        chk("wr_g1_be", 32'(s_if.be), 32'h2);
        chk("wr_g1_we", 32'(s_if.we), 1);
        tick();
        chk("wr_g2_ack", 32'(ack_v), 32'b1000);
        chk("wr_g2_addr", s_if.addr, 32'h400);
        tick();
        chk("wr_g3_ack", 32'(ack_v), 32'b0010);
        tick();
        chk("wr_g4_ack", 32'(ack_v), 32'b1000);
        tick();
        chk("wr_outst", 32'(outst), 0);

        // Four reads fill the FIFO; ptr is back at 0
        drive(4'b1111, 4'b0000);
        chk("rd_g0_ack", 32'(ack_v), 32'b0001);
        tick();
        chk("rd_g1_ack", 32'(ack_v), 32'b0010);
        tick();
        chk("rd_g2_ack", 32'(ack_v), 32'b0100);
        tick();
        chk("rd_g3_ack", 32'(ack_v), 32'b1000);
        tick();
        chk("full_outst", 32'(outst), 4);
        chk("full_ack", 32'(ack_v), 0);
        chk("full_sreq", 32'(s_if.req), 0);
        chk("full_saddr", s_if.addr, 0);
        drive(4'b1111, 4'b0100);
        chk("full_wr_ack", 32'(ack_v), 32'b0100);
        chk("full_wr_addr", s_if.addr, 32'h300);
        tick();
        chk("full_wr_outst", 32'(outst), 4);

        // Pop while full: read still blocked this cycle
        drive(4'b0001, 4'b0000);
        s_resp  = 1'b1;
        s_rdata = 32'h11;
        #1;
        chk("popfull_ack", 32'(ack_v), 0);
        chk("popfull_resp", 32'(resp_v), 32'b0001);
        chk("popfull_rd0", rd_a[0], 32'h11);
        chk("popfull_rd1", rd_a[1], 0);
        tick();
        chk("popfull_outst", 32'(outst), 3);
        drive(4'b0000, 4'b0000);
        s_rdata = 32'h22;
        #1;
        chk("drain1_resp", 32'(resp_v), 32'b0010);
        chk("drain1_rd1", rd_a[1], 32'h22);
        chk("drain1_rd0", rd_a[0], 0);
        tick();
        s_rdata = 32'h33;
        #1;
        chk("drain2_resp", 32'(resp_v), 32'b0100);
        tick();
        s_rdata = 32'h44;
        #1;
        chk("drain3_resp", 32'(resp_v), 32'b1000);
        chk("drain3_rd3", rd_a[3], 32'h44);
        tick();
        s_resp = 1'b0;
        #1;
        chk("drain_outst", 32'(outst), 0);
        chk("drain_err", 32'(err), 0);

        // Reads m2, m0, m1 then in-order responses (ptr=3)
        drive(4'b0100, 4'b0000);
        chk("ord_m2_ack", 32'(ack_v), 32'b0100);
        tick();
        drive(4'b0001, 4'b0000);
        chk("ord_m0_ack", 32'(ack_v), 32'b0001);
        tick();
        drive(4'b0010, 4'b0000);
        chk("ord_m1_ack", 32'(ack_v), 32'b0010);
        tick();
        drive(4'b0000, 4'b0000);
        chk("ord_outst", 32'(outst), 3);
        s_resp  = 1'b1;
        s_rdata = 32'hA;
        #1;
        chk("ord_a_resp", 32'(resp_v), 32'b0100);
        chk("ord_a_rd2", rd_a[2], 32'hA);
        tick();
        s_rdata = 32'hB;
        #1;
        chk("ord_b_resp", 32'(resp_v), 32'b0001);
        chk("ord_b_rd0", rd_a[0], 32'hB);
        tick();
        s_rdata = 32'hC;
        #1;
        chk("ord_c_resp", 32'(resp_v), 32'b0010);
        chk("ord_c_rd1", rd_a[1], 32'hC);
        tick();
        s_resp = 1'b0;
        #1;
        chk("ord_outst0", 32'(outst), 0);

        // Simultaneous push and pop (ptr=2)
        drive(4'b0001, 4'b0000);
        tick();
        drive(4'b0010, 4'b0000);
        tick();
        chk("pp_outst2", 32'(outst), 2);
        drive(4'b1000, 4'b0000);
        s_resp  = 1'b1;
        s_rdata = 32'h55;
        #1;
        chk("pp_ack", 32'(ack_v), 32'b1000);
        chk("pp_resp", 32'(resp_v), 32'b0001);
        tick();
        drive(4'b0000, 4'b0000);
        chk("pp_outst", 32'(outst), 2);
        chk("pp_next_resp", 32'(resp_v), 32'b0010);
        tick();
        chk("pp_last_resp", 32'(resp_v), 32'b1000);
        tick();
        s_resp = 1'b0;
        #1;
        chk("pp_outst0", 32'(outst), 0);
        chk("pp_err", 32'(err), 0);

        // Stray response sets sticky error
        s_resp = 1'b1;
        #1;
        chk("stray_resp", 32'(resp_v), 0);
        tick();
        s_resp = 1'b0;
        #1;
        chk("stray_err", 32'(err), 1);
        chk("stray_outst", 32'(outst), 0);
        tick();
        tick();
        chk("stray_err_hold", 32'(err), 1);

        // Async reset with three reads outstanding (ptr=0)
        drive(4'b0010, 4'b0000);
        tick();
        tick();
        tick();
        drive(4'b0000, 4'b0000);
        chk("pre_rst_outst", 32'(outst), 3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_outst", 32'(outst), 0);
        chk("arst_err", 32'(err), 0);
        drive(4'b0110, 4'b0110);
        chk("arst_grant", 32'(ack_v), 32'b0010);
        tick();
        chk("arst_hold", 32'(outst), 0);
        drive(4'b0000, 4'b0000);
        rst = 1'b1;
        drive(4'b1111, 4'b1111);
        chk("post_rst_ack", 32'(ack_v), 32'b0001);
        tick();
        chk("post_rst_ack2", 32'(ack_v), 32'b0010);
        drive(4'b0000, 4'b0000);
        s_resp = 1'b1;
        #1;
        chk("late_resp", 32'(resp_v), 0);
        tick();
        s_resp = 1'b0;
        #1;
        chk("late_err", 32'(err), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
